i2c_rx_byte_ctrl: RTL
=====================

I2C_RX_BYTE_CTRL -- requirements
Module: i2c_rx_byte_ctrl

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b1110001, 7-bit I2C slave address.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port scl  input  1  SCL level, already synchronized to clk.
REQ-005 SHALL have port sda_in  input  1  SDA level, already synchronized to clk.
REQ-006 SHALL have port rising_edge_found  input  1  one-cycle pulse, SCL rose; from the upstream SCL edge detector.
REQ-007 SHALL have port falling_edge_found  input  1  one-cycle pulse, SCL fell; from the upstream SCL edge detector.
REQ-008 SHALL have port rx_data  output  8  last complete received byte, MSB first on the wire.
REQ-009 SHALL have port byte_valid  output  1  one-cycle pulse, rx_data updated.
REQ-010 SHALL have port start_found  output  1  one-cycle pulse, START or repeated START detected.
REQ-011 SHALL have port stop_found  output  1  one-cycle pulse, STOP detected.
REQ-012 SHALL have port ack_slot  output  1  high during the 9th (ACK) SCL period.
REQ-013 SHALL have port sda_out_en  output  1  drive SDA low (ACK) when high.
REQ-014 SHALL have port addr_match  output  1  current transfer is addressed to SLAVE_ADDR.
REQ-015 SHALL have port rw_mode  output  1  R/W bit of the address byte.

Function
REQ-016 SHALL register sda_in every cycle into sda_prev.
REQ-017 SHALL detect START when scl==1, sda_prev==1 and sda_in==0.
REQ-018 SHALL detect STOP when scl==1, sda_prev==0 and sda_in==1.
REQ-019 SHALL pulse start_found and stop_found in the cycle after detection.
REQ-020 SHALL implement four states: IDLE, RECEIVE, ACK, WAIT.
REQ-021 SHALL ignore SCL edges in IDLE.
REQ-022 SHALL, on START from any state (including repeated START), enter RECEIVE with bit_cnt=0 and addr_match=0.
REQ-023 SHALL, on STOP from any state, enter IDLE and deassert ack_slot and sda_out_en in the same cycle.
REQ-024 SHALL give START/STOP priority over an edge pulse arriving in the same cycle; that edge is discarded.
REQ-025 SHALL, in RECEIVE on rising_edge_found, shift {shift_reg[6:0], sda_in} and increment the 4-bit bit_cnt.
REQ-026 SHALL, on the 8th rising edge, load rx_data and pulse byte_valid in the next cycle (1-cycle latency).
REQ-027 SHALL, on the falling_edge_found following the 8th bit, enter ACK with ack_slot=1.
REQ-028 SHALL, in ACK, assert sda_out_en together with ack_slot when addr_match==1.
REQ-029 SHALL, on the falling_edge_found that ends the 9th bit, deassert ack_slot and sda_out_en and clear bit_cnt.
REQ-030 SHALL then return to RECEIVE if addr_match==1, else enter WAIT.
REQ-031 SHALL, in WAIT, ignore all edges until the next START or STOP.
REQ-032 SHALL hold rx_data between byte_valid pulses.

Reset
REQ-033 SHALL, while rst==1 at a clk edge, set state=IDLE, bit_cnt=0, shift_reg=0, rx_data=0, sda_prev=1, and drive all pulse and flag outputs to 0.
REQ-034 SHALL, on rst mid-byte, discard the partial byte and produce no byte_valid.

Configuration
REQ-035 SHALL use macro I2C_RX_ADDR_MATCH_EN.
REQ-036 SHALL, when the macro is defined, treat the first byte after START as the address: set addr_match=1 iff rx_data[7:1]==SLAVE_ADDR, and set rw_mode=rx_data[0]; byte_valid still pulses for this byte.
REQ-037 SHALL, when the macro is undefined, set addr_match=1 at every START, tie rw_mode to 0, ACK every byte, and never enter WAIT.

Verification
REQ-038 SHALL cover: reset held 2 cycles -> all outputs 0, state IDLE; SCL edges while idle -> no byte_valid.
REQ-039 SHALL cover: START, byte 0xE2 (addr 0x71, W) -> start_found pulse, byte_valid with rx_data=0xE2, addr_match=1, rw_mode=0, sda_out_en high for the whole 9th SCL period.
REQ-040 SHALL cover: START, byte 0x10 (mismatch, macro defined) -> byte_valid with 0x10, addr_match=0, no sda_out_en; following byte 0xAA -> no byte_valid.
REQ-041 SHALL cover: addressed write then data 0x5A, 0xC3 -> two byte_valid pulses, 0x5A then 0xC3, each ACKed.
REQ-042 SHALL cover: STOP after 4 data bits -> stop_found pulse, state IDLE, no byte_valid; then a repeated START mid-byte -> bit_cnt=0 and a fresh 8 bits give a correct byte.
REQ-043 SHALL cover: START coincident with rising_edge_found -> edge ignored, bit_cnt=0.

Source files
------------

// File: rtl/i2c_rx_byte_ctrl.sv
// I2C slave receive path: START/STOP detection, byte assembly, ACK slot control.
// Optional address filtering is enabled by defining I2C_RX_ADDR_MATCH_EN.
module i2c_rx_byte_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1110001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       start_found,
    output logic       stop_found,
    output logic       ack_slot,
    output logic       sda_out_en,
    output logic       addr_match,
    output logic       rw_mode,
    output logic [1:0] dbg_state,
    output logic [3:0] dbg_bit_cnt
);

`ifdef I2C_RX_ADDR_MATCH_EN
    localparam logic ADDR_FILTER = 1'b1;
`else
    localparam logic ADDR_FILTER = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_ACK     = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift_reg;
    logic [7:0] r_rx_data;
    logic       r_sda_prev;
    logic       r_byte_valid;
    logic       r_start_found;
    logic       r_stop_found;
    logic       r_ack_slot;
    logic       r_sda_out_en;
    logic       r_addr_match;
    logic       r_rw_mode;
    logic       r_first_byte;

    logic       w_start;
    logic       w_stop;
    logic [7:0] w_shift_next;
    logic       w_addr_hit;

    // All pulse outputs (start_found, stop_found, byte_valid) are single-cycle,
    // registered, and carry no handshake: the consumer must sample them every cycle.
    assign w_start      = scl &  r_sda_prev & ~sda_in;
    assign w_stop       = scl & ~r_sda_prev &  sda_in;
    assign w_shift_next = {r_shift_reg[6:0], sda_in};
    assign w_addr_hit   = (w_shift_next[7:1] == SLAVE_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 4'd0;
            r_shift_reg   <= 8'd0;
            r_rx_data     <= 8'd0;
            r_sda_prev    <= 1'b1;
            r_byte_valid  <= 1'b0;
            r_start_found <= 1'b0;
            r_stop_found  <= 1'b0;
            r_ack_slot    <= 1'b0;
            r_sda_out_en  <= 1'b0;
            r_addr_match  <= 1'b0;
            r_rw_mode     <= 1'b0;
            r_first_byte  <= 1'b0;
        end else begin
            r_sda_prev    <= sda_in;
            r_start_found <= w_start;
            r_stop_found  <= w_stop;
            r_byte_valid  <= 1'b0;

            // Bus conditions win over any SCL edge in the same cycle; that edge is dropped.
            if (w_start) begin
                r_state      <= ST_RECEIVE;
                r_bit_cnt    <= 4'd0;
                r_shift_reg  <= 8'd0;
                r_ack_slot   <= 1'b0;
                r_sda_out_en <= 1'b0;
                r_addr_match <= ~ADDR_FILTER;
                r_first_byte <= 1'b1;
            end else if (w_stop) begin
                r_state      <= ST_IDLE;
                r_bit_cnt    <= 4'd0;
                r_ack_slot   <= 1'b0;
                r_sda_out_en <= 1'b0;
            end else begin
                case (r_state)
                    ST_RECEIVE: begin
                        if (rising_edge_found && (r_bit_cnt < 4'd8)) begin
                            r_shift_reg <= w_shift_next;
                            r_bit_cnt   <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_rx_data    <= w_shift_next;
                                r_byte_valid <= 1'b1;
                                r_first_byte <= 1'b0;
                                if (r_first_byte) begin
                                    r_addr_match <= ~ADDR_FILTER | w_addr_hit;
                                    r_rw_mode    <= ADDR_FILTER & w_shift_next[0];
                                end
                            end
                        end else if (falling_edge_found && (r_bit_cnt == 4'd8)) begin
                            r_state      <= ST_ACK;
                            r_ack_slot   <= 1'b1;
                            r_sda_out_en <= r_addr_match;
                        end
                    end
                    ST_ACK: begin
                        if (falling_edge_found) begin
                            r_ack_slot   <= 1'b0;
                            r_sda_out_en <= 1'b0;
                            r_bit_cnt    <= 4'd0;
                            r_state      <= r_addr_match ? ST_RECEIVE : ST_WAIT;
                        end
                    end
                    default: begin
                        // IDLE and WAIT ignore SCL edges until the next bus condition.
                    end
                endcase
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign byte_valid  = r_byte_valid;
    assign start_found = r_start_found;
    assign stop_found  = r_stop_found;
    assign ack_slot    = r_ack_slot;
    assign sda_out_en  = r_sda_out_en;
    assign addr_match  = r_addr_match;
    assign rw_mode     = r_rw_mode;
    assign dbg_state   = r_state;
    assign dbg_bit_cnt = r_bit_cnt;

endmodule
